// File: rtl/sqrt_pkg.sv
// Shared types and constants for the square-root-approximation controller.
package sqrt_pkg;

    localparam int unsigned AU_LAT_DEFAULT = 2;

    // AU1 function selects
    localparam logic [1:0] AU1_ABS_A = 2'b00;
    localparam logic [1:0] AU1_ABS_B = 2'b01;
    localparam logic [1:0] AU1_MAX   = 2'b10;
    localparam logic [1:0] AU1_MIN   = 2'b11;

    // AU2 function selects (2'b11 unused)
    localparam logic [1:0] AU2_ADD = 2'b00;
    localparam logic [1:0] AU2_SUB = 2'b01;
    localparam logic [1:0] AU2_MAX = 2'b10;

    typedef enum logic [3:0] {
        IDLE, LOAD, ABSA, ABSB, MAXS, MINS, SUBS, ADDS, MAXF, DONE
    } state_e;

    // Every control line the controller drives, in one registered bundle.
    typedef struct packed {
        logic       busy;
        logic       en_r1;
        logic       en_r2;
        logic       en_r3;
        logic       en_r4;
        logic       en_r5;
        logic       b1;
        logic       b6;
        logic [1:0] b2;
        logic [1:0] b3;
        logic [1:0] b4;
        logic [1:0] b5;
        logic [1:0] b7;
        logic [1:0] sel_au1;
        logic [1:0] sel_au2;
        logic       done;
    } ctrl_t;

    // States that run an AU operation and are paced by the step timer.
    function automatic logic is_step(state_e s);
        return s inside {ABSA, ABSB, MAXS, MINS, SUBS, ADDS, MAXF};
    endfunction

    // Control decode for a state; fire marks the final cycle of an AU step.
    function automatic ctrl_t ctrl_of(state_e s, logic fire);
        ctrl_t c;
        c = '0;
        case (s)
            LOAD: begin
                c.busy  = 1'b1;
                c.b3    = 2'b10;
                c.b4    = 2'b10;
                c.en_r1 = 1'b1;
                c.en_r2 = 1'b1;
            end
            ABSA: begin
                c.busy    = 1'b1;
                c.b1      = 1'b1;
                c.sel_au1 = AU1_ABS_A;
                c.b3      = 2'b01;
                c.en_r1   = fire;
            end
            ABSB: begin
                c.busy    = 1'b1;
                c.b2      = 2'b01;
                c.sel_au1 = AU1_ABS_B;
                c.b4      = 2'b01;
                c.en_r2   = fire;
            end
            MAXS: begin
                c.busy    = 1'b1;
                c.b1      = 1'b1;
                c.b2      = 2'b01;
                c.sel_au1 = AU1_MAX;
                c.b7      = 2'b10;
                c.en_r4   = fire;
                c.en_r3   = fire;
            end
            MINS: begin
                c.busy    = 1'b1;
                c.b1      = 1'b1;
                c.b2      = 2'b01;
                c.sel_au1 = AU1_MIN;
                c.en_r5   = fire;
            end
            SUBS: begin
                c.busy    = 1'b1;
                c.b5      = 2'b10;
                c.b6      = 1'b1;
                c.sel_au2 = AU2_SUB;
                c.b7      = 2'b01;
                c.en_r3   = fire;
            end
            ADDS: begin
                c.busy    = 1'b1;
                c.b5      = 2'b01;
                c.b6      = 1'b1;
                c.sel_au2 = AU2_ADD;
                c.b7      = 2'b01;
                c.en_r3   = fire;
            end
            MAXF: begin
                c.busy    = 1'b1;
                c.b5      = 2'b10;
                c.b6      = 1'b1;
                c.sel_au2 = AU2_MAX;
                c.b7      = 2'b01;
                c.en_r3   = fire;
            end
            DONE: c.done = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sqrt_step_timer.sv
// Per-step cycle counter: counts 0..AU_LAT inside an AU step.
module sqrt_step_timer
    import sqrt_pkg::*;
#(
    parameter int unsigned AU_LAT = AU_LAT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic last,
    output logic last_next
);
    localparam int unsigned CW = (AU_LAT < 1) ? 1 : $clog2(AU_LAT + 1);

    logic [CW-1:0] count_q, count_d;

    // Restart on clear, otherwise advance one per cycle.
    always_comb begin
        count_d = clear ? '0 : count_q + CW'(1);
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last      = (count_q == CW'(AU_LAT));
    // Lets the FSM register an enable so it lands exactly on the final cycle.
    assign last_next = (count_d == CW'(AU_LAT));

endmodule

// File: rtl/sqrt_controller.sv
// Sequencing FSM for the 8-bit square-root-approximation datapath.
module sqrt_controller
    import sqrt_pkg::*;
#(
    parameter int unsigned AU_LAT = AU_LAT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       en_R1,
    output logic       en_R2,
    output logic       en_R3,
    output logic       en_R4,
    output logic       en_R5,
    output logic       b1,
    output logic       b6,
    output logic [1:0] b2,
    output logic [1:0] b3,
    output logic [1:0] b4,
    output logic [1:0] b5,
    output logic [1:0] b7,
    output logic [1:0] sel_AU1,
    output logic [1:0] sel_AU2,
    output logic       Done
);
    state_e state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   last, last_next, clear;

    sqrt_step_timer #(
        .AU_LAT(AU_LAT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .last     (last),
        .last_next(last_next)
    );

    // Next state: LOAD lasts one cycle, AU steps advance on the timer's final cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    state_d = ABSA;
            ABSA:    if (last) state_d = ABSB;
            ABSB:    if (last) state_d = MAXS;
            MAXS:    if (last) state_d = MINS;
            MINS:    if (last) state_d = SUBS;
            SUBS:    if (last) state_d = ADDS;
            ADDS:    if (last) state_d = MAXF;
            MAXF:    if (last) state_d = DONE;
            DONE:    if (start) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    // Step count restarts on every state change and rests at 0 outside AU steps.
    assign clear = (state_d != state_q) || !is_step(state_d);

    // Outputs are decoded from the upcoming state so they register alongside it.
    always_comb begin
        ctrl_d = ctrl_of(state_d, last_next);
    end

    // State and Moore output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign busy    = ctrl_q.busy;
    assign en_R1   = ctrl_q.en_r1;
    assign en_R2   = ctrl_q.en_r2;
    assign en_R3   = ctrl_q.en_r3;
    assign en_R4   = ctrl_q.en_r4;
    assign en_R5   = ctrl_q.en_r5;
    assign b1      = ctrl_q.b1;
    assign b6      = ctrl_q.b6;
    assign b2      = ctrl_q.b2;
    assign b3      = ctrl_q.b3;
    assign b4      = ctrl_q.b4;
    assign b5      = ctrl_q.b5;
    assign b7      = ctrl_q.b7;
    assign sel_AU1 = ctrl_q.sel_au1;
    assign sel_AU2 = ctrl_q.sel_au2;
    assign Done    = ctrl_q.done;

    // Paired bus drivers must never fight.
    a_b2_pair: assert property (@(posedge clk) disable iff (!rst_n) b2 != 2'b11);
    a_b3_pair: assert property (@(posedge clk) disable iff (!rst_n) b3 != 2'b11);
    a_b4_pair: assert property (@(posedge clk) disable iff (!rst_n) b4 != 2'b11);
    a_b5_pair: assert property (@(posedge clk) disable iff (!rst_n) b5 != 2'b11);
    a_b7_pair: assert property (@(posedge clk) disable iff (!rst_n) b7 != 2'b11);

    // Bus3 and R1 loading belong to LOAD/ABSA only.
    a_b3_scope: assert property (@(posedge clk) disable iff (!rst_n)
        ((b3 != 2'b00) || en_R1) |-> (state_q inside {LOAD, ABSA}));

    // Register enables are single-cycle pulses.
    a_en1_pulse: assert property (@(posedge clk) disable iff (!rst_n) en_R1 |=> !en_R1);
    a_en2_pulse: assert property (@(posedge clk) disable iff (!rst_n) en_R2 |=> !en_R2);
    a_en3_pulse: assert property (@(posedge clk) disable iff (!rst_n) en_R3 |=> !en_R3);
    a_en4_pulse: assert property (@(posedge clk) disable iff (!rst_n) en_R4 |=> !en_R4);
    a_en5_pulse: assert property (@(posedge clk) disable iff (!rst_n) en_R5 |=> !en_R5);

endmodule

// File: tb/tb_sqrt_controller.sv
// Controller plus behavioural datapath; scoreboard of expected results.
module tb_sqrt_controller;
    import sqrt_pkg::*;

    localparam int unsigned AU_LAT = 2;
    localparam int STEP = AU_LAT + 1;
    localparam int LAST_K = 1 + 7 * STEP; // DONE cycle index after LOAD

    logic       clk = 1'b0;
    logic       rst_n, start;
    logic       busy, en_R1, en_R2, en_R3, en_R4, en_R5, b1, b6, Done;
    logic [1:0] b2, b3, b4, b5, b7, sel_AU1, sel_AU2;

    logic [7:0] a_in, b_in;
    logic [7:0] r1, r2, r3, r4, r5;
    logic [7:0] au1_s1, au1_s2, au2_s1, au2_s2;
    logic [7:0] bus1, bus2, bus5, bus6;
    logic [22:0] obs;

    logic [7:0] sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sqrt_controller #(
        .AU_LAT(AU_LAT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .busy   (busy),
        .en_R1  (en_R1),
        .en_R2  (en_R2),
        .en_R3  (en_R3),
        .en_R4  (en_R4),
        .en_R5  (en_R5),
        .b1     (b1),
        .b6     (b6),
        .b2     (b2),
        .b3     (b3),
        .b4     (b4),
        .b5     (b5),
        .b7     (b7),
        .sel_AU1(sel_AU1),
        .sel_AU2(sel_AU2),
        .Done   (Done)
    );

    assign obs = {busy, en_R1, en_R2, en_R3, en_R4, en_R5, b1, b6,
                  b2, b3, b4, b5, b7, sel_AU1, sel_AU2, Done};

    // Undriven buses read as X so a missing enable poisons the result.
    assign bus1 = b1 ? r1 : 8'hxx;
    assign bus2 = (b2 == 2'b01) ? r2 : 8'hxx;
    assign bus5 = (b5 == 2'b10) ? r4 : (b5 == 2'b01) ? r5 : 8'hxx;
    assign bus6 = b6 ? r3 : 8'hxx;

    function automatic logic [7:0] neg_abs(logic [7:0] v);
        return v[7] ? (~v + 8'd1) : v;
    endfunction

    function automatic logic [7:0] au1_f(logic [1:0] s, logic [7:0] x, logic [7:0] y);
        case (s)
            2'b00:   return neg_abs(x);
            2'b01:   return neg_abs(y);
            2'b10:   return (x > y) ? x : y;
            default: return (x < y) ? x : y;
        endcase
    endfunction

    function automatic logic [7:0] au2_f(logic [1:0] s, logic [7:0] x, logic [7:0] y);
        case (s)
            2'b00:   return x + y;
            2'b01:   return x - y;
            2'b10:   return (x > y) ? x : y;
            default: return 8'hxx;
        endcase
    endfunction

    // Two-stage AUs and the register file.
    always @(posedge clk) begin
        au1_s1 <= au1_f(sel_AU1, bus1, bus2);
        au1_s2 <= au1_s1;
        au2_s1 <= au2_f(sel_AU2, bus5, bus6);
        au2_s2 <= au2_s1;
        if (en_R1) r1 <= (b3 == 2'b10) ? a_in : (b3 == 2'b01) ? au1_s2 : 8'hxx;
        if (en_R2) r2 <= (b4 == 2'b10) ? b_in : (b4 == 2'b01) ? au1_s2 : 8'hxx;
        if (en_R4) r4 <= au1_s2;
        if (en_R5) r5 <= au1_s2 >> 1;
        if (en_R3) r3 <= (b7 == 2'b10) ? (au1_s2 >> 3) : (b7 == 2'b01) ? au2_s2 : 8'hxx;
    end

    function automatic logic [7:0] sqrt_ref(logic [7:0] a, logic [7:0] b);
        logic [7:0] aa, bb, x, y, t;
        aa = neg_abs(a);
        bb = neg_abs(b);
        x = (aa > bb) ? aa : bb;
        y = (aa > bb) ? bb : aa;
        t = x - (x >> 3) + (y >> 1);
        return (t > x) ? t : x;
    endfunction

    // Expected control vector k cycles after LOAD begins.
    function automatic logic [22:0] exp_ctrl(int k);
        logic bz, e1, e2, e3, e4, e5, x1, x6, dn, fin;
        logic [1:0] y2, y3, y4, y5, y7, s1, s2;
        {bz, e1, e2, e3, e4, e5, x1, x6, dn} = '0;
        {y2, y3, y4, y5, y7, s1, s2} = '0;
        if (k == 0) begin
            bz = 1; y3 = 2'b10; y4 = 2'b10; e1 = 1; e2 = 1;
        end else if (k < LAST_K) begin
            bz = 1;
            fin = ((k - 1) % STEP) == STEP - 1;
            case ((k - 1) / STEP)
                0: begin x1 = 1; s1 = 2'b00; y3 = 2'b01; e1 = fin; end
                1: begin y2 = 2'b01; s1 = 2'b01; y4 = 2'b01; e2 = fin; end
                2: begin x1 = 1; y2 = 2'b01; s1 = 2'b10; y7 = 2'b10; e4 = fin; e3 = fin; end
                3: begin x1 = 1; y2 = 2'b01; s1 = 2'b11; e5 = fin; end
                4: begin y5 = 2'b10; x6 = 1; s2 = 2'b01; y7 = 2'b01; e3 = fin; end
                5: begin y5 = 2'b01; x6 = 1; s2 = 2'b00; y7 = 2'b01; e3 = fin; end
                default: begin y5 = 2'b10; x6 = 1; s2 = 2'b10; y7 = 2'b01; e3 = fin; end
            endcase
        end else begin
            dn = 1;
        end
        return {bz, e1, e2, e3, e4, e5, x1, x6, y2, y3, y4, y5, y7, s1, s2, dn};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // One operation from the cycle before LOAD through DONE.
    // mode: 0 plain, 1/2 intermediate probes, 3 reset during SUBS.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit hold,
                          input int mode);
        a_in = a;
        b_in = b;
        start = 1'b1;
        sb.push_back(sqrt_ref(a, b));
        for (int k = 0; k <= LAST_K; k++) begin
            @(negedge clk);
            if (!hold) start = (k == 10); // a pulse while busy must be ignored
            check($sformatf("ctrl[k=%0d]", k), 32'(obs), 32'(exp_ctrl(k)));
            if (mode == 1 && k == 4)  check("r1_abs", 32'(r1), 32'd8);
            if (mode == 1 && k == 10) check("r4_max", 32'(r4), 32'd8);
            if (mode == 1 && k == 10) check("r3_shr3", 32'(r3), 32'd1);
            if (mode == 1 && k == 13) check("r5_shr1", 32'(r5), 32'd3);
            if (mode == 2 && k == 16) check("r3_sub", 32'(r3), 32'd88);
            if (mode == 2 && k == 19) check("r3_add", 32'(r3), 32'd88);
            if (mode == 3 && k == 14) begin
                rst_n = 1'b0;
                #1;
                check("async_rst_outs", 32'(obs), 32'd0);
                check("async_rst_state", 32'(dut.state_q), 32'(IDLE));
                sb.delete();
                return;
            end
            if (k == LAST_K) begin
                if (sb.size() == 0) begin
                    check("sb_empty", 32'd1, 32'd0);
                end else begin
                    check("result", 32'(r3), 32'(sb.pop_front()));
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a_in = 8'd0;
        b_in = 8'd0;
        repeat (2) @(negedge clk);
        check("reset_outs", 32'(obs), 32'd0);
        check("reset_state", 32'(dut.state_q), 32'(IDLE));
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outs", 32'(obs), 32'd0);

        run_op(8'd3, 8'd4, 1'b0, 0);
        run_op(8'hF8, 8'd6, 1'b0, 1);
        run_op(8'd100, 8'd0, 1'b0, 2);

        run_op(8'd3, 8'd4, 1'b0, 3);
        @(negedge clk);
        check("rst_held_outs", 32'(obs), 32'd0);
        rst_n = 1'b1;
        run_op(8'd0, 8'd0, 1'b0, 0);

        // start held high: back-to-back operations, no dead cycles
        for (int i = 0; i < 3; i++) run_op(8'd3, 8'd4, 1'b1, 0);
        start = 1'b0;
        @(negedge clk);
        check("done_holds", 32'(obs), 32'(exp_ctrl(LAST_K)));
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
